// File: rtl/ysyx_24120009_decode_exec.sv
// Purpose : RV32I single-cycle decode, control and execute datapath (IFU/regfile -> dmem/write-back).
// Latency : all outputs combinational in the same cycle as inst; only 'halted' is registered.
// Backpressure: none; the block consumes one instruction per cycle and never stalls.
// Ports:
//   clk, rst (async active-low)             - clock / reset for the halted flop
//   inst, pc, pc_plus4                      - current instruction and its addresses
//   rs1_data, rs2_data, dmem_rdata          - regfile read data, aligned load data
//   rs1_addr, rs2_addr, rd_addr, rf_we,
//   reg_write_data                          - register file interface
//   op1, op2, dmem_addr                     - ALU operands (debug) and ALU result
//   mem_en, mem_wen, ctl_mem_access         - data memory control
//   pc_sel, br_target, jmp_target,
//   jump_reg_target                         - next-pc selection and candidates
//   is_ebreak, halted                       - ebreak decode and sticky halt status
module ysyx_24120009_decode_exec #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               inst,
   input  logic [DATA_WIDTH-1:0]     pc,
   input  logic [DATA_WIDTH-1:0]     pc_plus4,
   input  logic [DATA_WIDTH-1:0]     rs1_data,
   input  logic [DATA_WIDTH-1:0]     rs2_data,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata,
   output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
   output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr,
   output logic                      rf_we,
   output logic [DATA_WIDTH-1:0]     reg_write_data,
   output logic [DATA_WIDTH-1:0]     op1,
   output logic [DATA_WIDTH-1:0]     op2,
   output logic [DATA_WIDTH-1:0]     dmem_addr,
   output logic                      mem_en,
   output logic                      mem_wen,
   output logic [2:0]                ctl_mem_access,
   output logic [2:0]                pc_sel,
   output logic [DATA_WIDTH-1:0]     br_target,
   output logic [DATA_WIDTH-1:0]     jmp_target,
   output logic [DATA_WIDTH-1:0]     jump_reg_target,
   output logic                      is_ebreak,
   output logic                      halted
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode   = inst[6:0];
   assign funct3   = inst[14:12];
   assign funct7   = inst[31:25];
   assign rs1_addr = inst[19:15];
   assign rs2_addr = inst[24:20];
   assign rd_addr  = inst[11:7];

   // Sign-extended immediates, built at 32 bits and then extended to the datapath width.
   logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = DATA_WIDTH'($signed({{20{inst[31]}}, inst[31:20]}));
   assign imm_s = DATA_WIDTH'($signed({{20{inst[31]}}, inst[31:25], inst[11:7]}));
   assign imm_b = DATA_WIDTH'($signed({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign imm_u = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
   assign imm_j = DATA_WIDTH'($signed({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

   assign is_ebreak = (inst == 32'h0010_0073);

   // Decode
   logic                  legal;
   logic                  wr_rd;
   logic                  is_load;
   logic                  is_store;
   logic                  is_branch;
   logic                  is_jal;
   logic                  is_jalr;
   logic                  use_rs2;
   logic                  alu_alt;     // SUB / SRA select
   logic [2:0]            alu_f3;
   op1_sel_t              op1_sel;
   wb_sel_t               wb_sel;
   logic [DATA_WIDTH-1:0] imm;

   always_comb begin
      legal     = 1'b0;
      wr_rd     = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      use_rs2   = 1'b0;
      alu_alt   = 1'b0;
      alu_f3    = 3'b000;
      op1_sel   = OP1_RS1;
      wb_sel    = WB_ALU;
      imm       = imm_i;
      unique case (opcode)
         OPC_LUI: begin
            legal   = 1'b1;
            wr_rd   = 1'b1;
            op1_sel = OP1_ZERO;
            imm     = imm_u;
         end
         OPC_AUIPC: begin
            legal   = 1'b1;
            wr_rd   = 1'b1;
            op1_sel = OP1_PC;
            imm     = imm_u;
         end
         OPC_JAL: begin
            legal   = 1'b1;
            wr_rd   = 1'b1;
            is_jal  = 1'b1;
            op1_sel = OP1_PC;
            wb_sel  = WB_PC4;
            imm     = imm_j;
         end
         OPC_JALR: begin
            legal   = (funct3 == 3'b000);
            wr_rd   = 1'b1;
            is_jalr = 1'b1;
            op1_sel = OP1_PC;
            wb_sel  = WB_PC4;
         end
         OPC_BRANCH: begin
            legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
            is_branch = 1'b1;
            use_rs2   = 1'b1;
            imm       = imm_b;
         end
         OPC_LOAD: begin
            legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
            wr_rd   = 1'b1;
            is_load = 1'b1;
            wb_sel  = WB_MEM;
         end
         OPC_STORE: begin
            legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            is_store = 1'b1;
            imm      = imm_s;
         end
         OPC_OPIMM: begin
            wr_rd  = 1'b1;
            alu_f3 = funct3;
            // Only shifts constrain the upper immediate bits; inst[30] picks SRAI.
            if (funct3 == 3'b001)
               legal = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101) begin
               legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               alu_alt = inst[30];
            end else
               legal = 1'b1;
         end
         OPC_OP: begin
            wr_rd   = 1'b1;
            use_rs2 = 1'b1;
            alu_f3  = funct3;
            alu_alt = inst[30];
            legal   = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         default: legal = 1'b0;
      endcase
   end

   // Operands and ALU
   logic [DATA_WIDTH-1:0] alu_res;
   logic [4:0]            shamt;

   always_comb begin
      unique case (op1_sel)
         OP1_PC:   op1 = pc;
         OP1_ZERO: op1 = '0;
         default:  op1 = rs1_data;
      endcase
   end

   assign op2   = use_rs2 ? rs2_data : imm;
   assign shamt = op2[4:0];

   always_comb begin
      unique case (alu_f3)
         3'b000:  alu_res = alu_alt ? (op1 - op2) : (op1 + op2);
         3'b001:  alu_res = op1 << shamt;
         3'b010:  alu_res = DATA_WIDTH'($signed(op1) < $signed(op2));
         3'b011:  alu_res = DATA_WIDTH'(op1 < op2);
         3'b100:  alu_res = op1 ^ op2;
         3'b101:  alu_res = alu_alt ? DATA_WIDTH'($signed(op1) >>> shamt) : (op1 >> shamt);
         3'b110:  alu_res = op1 | op2;
         default: alu_res = op1 & op2;
      endcase
   end

   assign dmem_addr = alu_res;

   // Branch resolution on raw register data, independent of the ALU.
   logic br_taken;

   always_comb begin
      unique case (funct3)
         3'b000:  br_taken = (rs1_data == rs2_data);
         3'b001:  br_taken = (rs1_data != rs2_data);
         3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
         3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  br_taken = (rs1_data < rs2_data);
         3'b111:  br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   assign br_target       = pc + imm_b;
   assign jmp_target      = pc + imm_j;
   assign jump_reg_target = (rs1_data + imm_i) & ~DATA_WIDTH'(1);

   always_comb begin
      pc_sel = 3'd0;
      if (legal) begin
         if (is_jal)
            pc_sel = 3'd2;
         else if (is_jalr)
            pc_sel = 3'd3;
         else if (is_branch && br_taken)
            pc_sel = 3'd1;
      end
   end

   always_comb begin
      unique case (wb_sel)
         WB_MEM:  reg_write_data = dmem_rdata;
         WB_PC4:  reg_write_data = pc_plus4;
         default: reg_write_data = alu_res;
      endcase
   end

   // Side-effecting controls are squashed for illegal instructions and once halted.
   logic commit;

   assign commit         = legal && !halted;
   assign rf_we          = commit && wr_rd && (rd_addr != '0);
   assign mem_en         = commit && (is_load || is_store);
   assign mem_wen        = commit && is_store;
   assign ctl_mem_access = (legal && (is_load || is_store)) ? funct3 : 3'b000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         halted <= 1'b0;
      else if (is_ebreak)
         halted <= 1'b1;
   end

endmodule

// File: tb/tb_ysyx_24120009_decode_exec.sv
module tb_ysyx_24120009_decode_exec;

   logic        clk;
   logic        rst;
   logic [31:0] inst, pc, pc_plus4, rs1_data, rs2_data, dmem_rdata;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rf_we, mem_en, mem_wen, is_ebreak, halted;
   logic [31:0] reg_write_data, op1, op2, dmem_addr;
   logic [31:0] br_target, jmp_target, jump_reg_target;
   logic [2:0]  ctl_mem_access, pc_sel;

   int checks   = 0;
   int failures = 0;

   ysyx_24120009_decode_exec #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .inst(inst), .pc(pc), .pc_plus4(pc_plus4),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .dmem_rdata(dmem_rdata),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rf_we(rf_we), .reg_write_data(reg_write_data), .op1(op1), .op2(op2),
      .dmem_addr(dmem_addr), .mem_en(mem_en), .mem_wen(mem_wen),
      .ctl_mem_access(ctl_mem_access), .pc_sel(pc_sel), .br_target(br_target),
      .jmp_target(jmp_target), .jump_reg_target(jump_reg_target),
      .is_ebreak(is_ebreak), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {F_RD, F_RFWE, F_WD, F_MEMEN, F_MEMWEN, F_CTL, F_PCSEL,
                     F_BRT, F_JMPT, F_JRT, F_DADDR, F_EBRK, F_HALT} field_t;

   typedef struct {
      string       tag;
      field_t      field;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   function automatic logic [31:0] get_obs(field_t f);
      case (f)
         F_RD:     return 32'(rd_addr);
         F_RFWE:   return 32'(rf_we);
         F_WD:     return reg_write_data;
         F_MEMEN:  return 32'(mem_en);
         F_MEMWEN: return 32'(mem_wen);
         F_CTL:    return 32'(ctl_mem_access);
         F_PCSEL:  return 32'(pc_sel);
         F_BRT:    return br_target;
         F_JMPT:   return jmp_target;
         F_JRT:    return jump_reg_target;
         F_DADDR:  return dmem_addr;
         F_EBRK:   return 32'(is_ebreak);
         default:  return 32'(halted);
      endcase
   endfunction

   task automatic expect_val(input string tag, input field_t f, input logic [31:0] v);
      exp_t e;
      e.tag   = tag;
      e.field = f;
      e.exp   = v;
      sb.push_back(e);
   endtask

   // Outputs are combinational: settle for 1ns, then pop and compare everything queued.
   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = get_obs(e.field);
         checks++;
         assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] md);
      @(negedge clk);
      inst       = i;
      pc         = p;
      pc_plus4   = p + 32'd4;
      rs1_data   = r1;
      rs2_data   = r2;
      dmem_rdata = md;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      inst = 32'h0000_0013; pc = 32'h8000_0000; pc_plus4 = 32'h8000_0004;
      rs1_data = '0; rs2_data = '0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      expect_val("reset_halted", F_HALT, 32'd0);
      drain();
      @(negedge clk);
      rst = 1'b1;

      // addi x1,x0,5
      drive(32'h0050_0093, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
      expect_val("addi_rd", F_RD, 32'd1);
      expect_val("addi_rfwe", F_RFWE, 32'd1);
      expect_val("addi_wd", F_WD, 32'd5);
      expect_val("addi_memen", F_MEMEN, 32'd0);
      expect_val("addi_pcsel", F_PCSEL, 32'd0);
      drain();

      // addi x0,x0,5: write to x0 suppressed
      drive(32'h0050_0013, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
      expect_val("addi_x0_rfwe", F_RFWE, 32'd0);
      drain();

      // beq x1,x2,8 taken / not taken
      drive(32'h0020_8463, 32'h8000_0000, 32'd7, 32'd7, 32'd0);
      expect_val("beq_taken_pcsel", F_PCSEL, 32'd1);
      expect_val("beq_brt", F_BRT, 32'h8000_0008);
      expect_val("beq_rfwe", F_RFWE, 32'd0);
      drain();
      drive(32'h0020_8463, 32'h8000_0000, 32'd7, 32'd8, 32'd0);
      expect_val("beq_nt_pcsel", F_PCSEL, 32'd0);
      drain();

      // blt (signed) taken vs bltu not taken for -1 vs 1
      drive(32'h0020_C463, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
      expect_val("blt_pcsel", F_PCSEL, 32'd1);
      drain();
      drive(32'h0020_E463, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
      expect_val("bltu_pcsel", F_PCSEL, 32'd0);
      drain();

      // sw x2,4(x1)
      drive(32'h0020_A223, 32'h8000_0000, 32'h8000_1000, 32'h1234_5678, 32'd0);
      expect_val("sw_daddr", F_DADDR, 32'h8000_1004);
      expect_val("sw_memen", F_MEMEN, 32'd1);
      expect_val("sw_memwen", F_MEMWEN, 32'd1);
      expect_val("sw_ctl", F_CTL, 32'd2);
      expect_val("sw_rfwe", F_RFWE, 32'd0);
      drain();

      // lw x3,0(x1)
      drive(32'h0000_A183, 32'h8000_0000, 32'h8000_2000, 32'd0, 32'hDEAD_BEEF);
      expect_val("lw_wd", F_WD, 32'hDEAD_BEEF);
      expect_val("lw_memen", F_MEMEN, 32'd1);
      expect_val("lw_memwen", F_MEMWEN, 32'd0);
      expect_val("lw_daddr", F_DADDR, 32'h8000_2000);
      expect_val("lw_rfwe", F_RFWE, 32'd1);
      drain();

      // jalr x1,3(x5) with pc_plus4 = 0x80000010
      drive(32'h0032_80E7, 32'h8000_000C, 32'h8000_0100, 32'd0, 32'd0);
      expect_val("jalr_pcsel", F_PCSEL, 32'd3);
      expect_val("jalr_jrt", F_JRT, 32'h8000_0102);
      expect_val("jalr_wd", F_WD, 32'h8000_0010);
      drain();

      // jal x1,8
      drive(32'h0080_00EF, 32'h8000_0040, 32'd0, 32'd0, 32'd0);
      expect_val("jal_pcsel", F_PCSEL, 32'd2);
      expect_val("jal_jmpt", F_JMPT, 32'h8000_0048);
      expect_val("jal_wd", F_WD, 32'h8000_0044);
      drain();

      // sra x3,x1,x2
      drive(32'h4020_D1B3, 32'h8000_0000, 32'h8000_0000, 32'd4, 32'd0);
      expect_val("sra_wd", F_WD, 32'hF800_0000);
      drain();

      // lui x5,0x12345
      drive(32'h1234_52B7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
      expect_val("lui_wd", F_WD, 32'h1234_5000);
      expect_val("lui_rd", F_RD, 32'd5);
      drain();

      // illegal opcode
      drive(32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd7, 32'd0);
      expect_val("ill_rfwe", F_RFWE, 32'd0);
      expect_val("ill_memen", F_MEMEN, 32'd0);
      expect_val("ill_memwen", F_MEMWEN, 32'd0);
      expect_val("ill_pcsel", F_PCSEL, 32'd0);
      expect_val("ill_ebrk", F_EBRK, 32'd0);
      drain();

      // ebreak: decoded immediately, halted only after the next rising edge
      drive(32'h0010_0073, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
      expect_val("ebreak_flag", F_EBRK, 32'd1);
      expect_val("ebreak_pre_halt", F_HALT, 32'd0);
      drain();
      @(posedge clk);
      #1;
      inst = 32'h0050_0093;
      expect_val("halt_set", F_HALT, 32'd1);
      expect_val("halt_addi_rfwe", F_RFWE, 32'd0);
      drain();
      drive(32'h0020_A223, 32'h8000_0000, 32'h8000_1000, 32'd0, 32'd0);
      expect_val("halt_sw_memen", F_MEMEN, 32'd0);
      expect_val("halt_sw_memwen", F_MEMWEN, 32'd0);
      expect_val("halt_sticky", F_HALT, 32'd1);
      drain();

      // async reset mid-cycle clears halted without a clock edge
      @(posedge clk);
      #3;
      rst = 1'b0;
      expect_val("async_clear", F_HALT, 32'd0);
      drain();
      @(negedge clk);
      rst = 1'b1;
      drive(32'h0050_0093, 32'h8000_0000, 32'd0, 32'd0, 32'd0);
      expect_val("post_reset_rfwe", F_RFWE, 32'd1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
